// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// instr_pkg: MIPS field widths, split-field struct and the splitting function
// Revision: 1.0
// ============================================================================
package instr_pkg;

  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNC_W  = 6;
  localparam int IMM16_W = 16;
  localparam int IMM26_W = 26;

  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNC_W-1:0]  func;
    logic [IMM16_W-1:0] imm16;
    logic [IMM26_W-1:0] imm26;
  } instr_fields_t;

  // Overlapping R/I/J views of the same word; decode picks the one it needs.
  function automatic instr_fields_t split_instr(input logic [31:0] word);
    instr_fields_t f;
    f.opcode = word[31:26];
    f.rs     = word[25:21];
    f.rt     = word[20:16];
    f.rd     = word[15:11];
    f.shamt  = word[10:6];
    f.func   = word[5:0];
    f.imm16  = word[15:0];
    f.imm26  = word[25:0];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_field_split.sv
`default_nettype none
// ============================================================================
// instr_field_split: combinational word-to-fields split, zeroed when !valid
// Revision: 1.0
// ============================================================================
module instr_field_split
  import instr_pkg::*;
(
  input  logic [31:0]   instr,
  input  logic          valid,
  output instr_fields_t fields
);

  assign fields = valid ? split_instr(instr) : '0;

endmodule
`default_nettype wire

// File: rtl/instr_queue_splitter.sv
`default_nettype none
// ============================================================================
// instr_queue_splitter: circular fetch->decode queue, head split into fields.
// Optional macro IQ_BYPASS_EN: empty-queue combinational bypass of in_* words.
// Revision: 1.0
// ============================================================================
module instr_queue_splitter
  import instr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_W-1:0]            opcode,
  output logic [REG_W-1:0]           rs,
  output logic [REG_W-1:0]           rt,
  output logic [REG_W-1:0]           rd,
  output logic [SHAMT_W-1:0]         shamt,
  output logic [FUNC_W-1:0]          func,
  output logic [IMM16_W-1:0]         imm16,
  output logic [IMM26_W-1:0]         imm26,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [31:0]      r_mem_instr [DEPTH];
  logic [PC_W-1:0]  r_mem_pc    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head_instr;
  logic [PC_W-1:0]  w_head_pc;
  instr_fields_t    w_fields;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign in_ready = !w_full;
  assign count    = r_count;

`ifdef IQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass     = w_empty && in_valid && !flush;
  assign out_valid    = !w_empty || w_bypass;
  // A bypassed word taken by decode the same cycle never enters storage.
  assign w_push       = in_valid && in_ready && !(w_bypass && out_ready);
  assign w_pop        = !w_empty && out_ready;
  assign w_head_instr = w_bypass ? in_instr : r_mem_instr[r_rd_ptr];
  assign w_head_pc    = w_bypass ? in_pc    : r_mem_pc[r_rd_ptr];
`else
  assign out_valid    = !w_empty;
  assign w_push       = in_valid && in_ready;
  assign w_pop        = out_valid && out_ready;
  assign w_head_instr = r_mem_instr[r_rd_ptr];
  assign w_head_pc    = r_mem_pc[r_rd_ptr];
`endif

  instr_field_split u_split (
    .instr  (w_head_instr),
    .valid  (out_valid),
    .fields (w_fields)
  );

  assign opcode = w_fields.opcode;
  assign rs     = w_fields.rs;
  assign rt     = w_fields.rt;
  assign rd     = w_fields.rd;
  assign shamt  = w_fields.shamt;
  assign func   = w_fields.func;
  assign imm16  = w_fields.imm16;
  assign imm26  = w_fields.imm26;
  assign out_pc = out_valid ? w_head_pc : '0;

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem_instr[r_wr_ptr] <= in_instr;
      r_mem_pc[r_wr_ptr]    <= in_pc;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_queue_splitter.sv
`default_nettype none
// ============================================================================
// tb_instr_queue_splitter: directed + randomized bench against a queue model
// Revision: 1.0
// ============================================================================
module tb_instr_queue_splitter;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int OBS_W = 1 + 1 + CW + 6 + 5*4 + 6 + 16 + 26 + PC_W;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd, shamt;
  logic [5:0]      func;
  logic [15:0]     imm16;
  logic [25:0]     imm26;
  logic [PC_W-1:0] out_pc;
  logic [CW-1:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] q[$];

  always #5 clk = ~clk;

  instr_queue_splitter #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .func(func), .imm16(imm16), .imm26(imm26),
    .out_pc(out_pc), .count(count)
  );

  logic [OBS_W-1:0] dut_obs;
  assign dut_obs = {out_valid, in_ready, count, opcode, rs, rt, rd, shamt,
                    func, imm16, imm26, out_pc};

  // Expected outputs from the model: head of queue (or bypassed input word).
  function automatic logic [OBS_W-1:0] exp_obs();
    logic [31:0]     w;
    logic [PC_W-1:0] p;
    logic            v;
    v = (q.size() > 0);
    w = '0;
    p = '0;
    if (v) begin
      w = q[0][63:32];
      p = q[0][31:0];
    end
`ifdef IQ_BYPASS_EN
    else if (in_valid && !flush) begin
      v = 1'b1;
      w = in_instr;
      p = in_pc;
    end
`endif
    return {v, (q.size() < DEPTH), CW'(q.size()), w[31:26], w[25:21],
            w[20:16], w[15:11], w[10:6], w[5:0], w[15:0], w[25:0], p};
  endfunction

  // Advance one clock edge, updating the model from the handshake rules.
  task automatic tick();
    bit          acc, pop, byp;
    logic [63:0] tmp;
    byp = 1'b0;
`ifdef IQ_BYPASS_EN
    byp = (q.size() == 0) && in_valid && !flush;
`endif
    acc = in_valid && (q.size() < DEPTH);
    pop = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) tmp = q.pop_front();
      if (acc && !(byp && out_ready)) q.push_back({in_instr, in_pc});
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_instr = '0; in_pc = '0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_obs !== exp_obs() || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", dut_obs, exp_obs());
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_push();
    in_valid = 1'b1; in_instr = 32'h8C4B0004; in_pc = 32'h3000; out_ready = 1'b0;
    #1;
    n_cmp++;
    if (dut_obs !== exp_obs()) begin
      n_bad++;
      $display("FAIL push_latency: got %h want %h", dut_obs, exp_obs());
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if ({out_valid, opcode, rs, rt, imm16, out_pc, count} !==
        {1'b1, 6'h23, 5'd2, 5'd11, 16'h0004, 32'h3000, CW'(1)}) begin
      n_bad++;
      $display("FAIL lw_fields: got v=%b op=%h rs=%0d rt=%0d imm=%h pc=%h cnt=%0d want 1 23 2 11 0004 3000 1",
               out_valid, opcode, rs, rt, imm16, out_pc, count);
    end
    drain();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = $urandom; in_pc = 32'h100 + 4*i;
      tick();
    end
    in_instr = 32'hDEADBEEF; in_pc = 32'hFFF0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
      n_bad++;
      $display("FAIL fill_full: got ready=%b count=%0d want 0 %0d", in_ready, count, DEPTH);
    end
    tick();
    n_cmp++;
    if (count !== CW'(DEPTH) || out_pc !== 32'h100 || dut_obs !== exp_obs()) begin
      n_bad++;
      $display("FAIL fill_reject: got count=%0d pc=%h want %0d 00000100", count, out_pc, DEPTH);
    end
  endtask

  task automatic test_full_pop();
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h12345678; in_pc = 32'hABC;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (count !== CW'(DEPTH-1) || in_ready !== 1'b1 || dut_obs !== exp_obs()) begin
      n_bad++;
      $display("FAIL full_pop: got count=%0d ready=%b want %0d 1", count, in_ready, DEPTH-1);
    end
    drain();
  endtask

  task automatic test_stream();
    in_valid = 1'b1; in_instr = 32'h014B4821; in_pc = 32'h4000; out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 3*DEPTH; i++) begin
      in_pc = 32'h4000 + 4*i;
      #1;
      n_cmp++;
      if (count !== CW'(1) || rd !== 5'd9 || func !== 6'h21 ||
          out_pc !== 32'h4000 + 4*(i-1) || dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL stream[%0d]: got count=%0d rd=%0d func=%h pc=%h want 1 9 21 %h",
                 i, count, rd, func, out_pc, 32'h4000 + 4*(i-1));
      end
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = $urandom; in_pc = 32'h500 + 4*i;
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h11111111;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_pc !== 32'h500) begin
      n_bad++;
      $display("FAIL flush_cycle: got v=%b ready=%b pc=%h want 1 1 00000500", out_valid, in_ready, out_pc);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (dut_obs !== {1'b0, 1'b1, {(OBS_W-2){1'b0}}}) begin
      n_bad++;
      $display("FAIL flush_after: got %h want all-zero with ready=1", dut_obs);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h600 + 4*i;
      tick();
    end
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || count !== '0 || opcode !== '0 || imm26 !== '0 || out_pc !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b count=%0d op=%h imm26=%h pc=%h want all 0",
               out_valid, count, opcode, imm26, out_pc);
    end
    q.delete();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef IQ_BYPASS_EN
  task automatic test_bypass();
    in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h44; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h44) begin
      n_bad++;
      $display("FAIL bypass_comb: got v=%b pc=%h want 1 00000044", out_valid, out_pc);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (count !== '0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass_consume: got count=%0d v=%b want 0 0", count, out_valid);
    end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h8C4B0004;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || opcode !== '0) begin
      n_bad++;
      $display("FAIL bypass_flush: got v=%b op=%h want 0 00", out_valid, opcode);
    end
    tick();
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = $urandom;
      in_pc     = $urandom;
      #1;
      n_cmp++;
      if (dut_obs !== exp_obs()) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_obs, exp_obs());
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill();
    test_full_pop();
    test_stream();
    test_flush();
    test_async_reset();
`ifdef IQ_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
